// File: rtl/cache_pkg.sv
// cache_pkg: line-state encodings, snoop codes, response bit indices and snoop FSM states.
package cache_pkg;
  localparam logic [2:0] ST_UC = 3'b000;
  localparam logic [2:0] ST_UD = 3'b001;
  localparam logic [2:0] ST_SC = 3'b010;
  localparam logic [2:0] ST_SD = 3'b011;
  localparam logic [2:0] ST_I  = 3'b100;
  localparam logic [3:0] SN_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SN_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SN_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SN_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SN_MAKE_INVALID  = 4'b1101;
  localparam int CRRESP_W = 5;
  localparam int CR_DT = 0;
  localparam int CR_ERR = 1;
  localparam int CR_PD = 2;
  localparam int CR_IS = 3;
  localparam int CR_WU = 4;
  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, DATA, UPDATE} snoop_fsm_e;
endpackage

// File: rtl/snoop_controller_if.sv
// snoop_controller_if: AC/CR/CD snoop channel bundle between interconnect (master) and cache (slave).
interface snoop_controller_if import cache_pkg::*; #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic acvalid;
  logic acready;
  logic [ADDR_WIDTH-1:0] acaddr;
  logic [3:0] acsnoop;
  logic crvalid;
  logic crready;
  logic [CRRESP_W-1:0] crresp;
  logic cdvalid;
  logic cdready;
  logic [DATA_WIDTH-1:0] cddata;
  logic cdlast;
  modport master (output acvalid, acaddr, acsnoop, crready, cdready,
                  input acready, crvalid, crresp, cdvalid, cddata, cdlast);
  modport slave (input acvalid, acaddr, acsnoop, crready, cdready,
                 output acready, crvalid, crresp, cdvalid, cddata, cdlast);
endinterface

// File: rtl/snoop_resp_decode.sv
// snoop_resp_decode: snoop response, next line state and write enable from snoop type and lookup result.
module snoop_resp_decode import cache_pkg::*; #(parameter int WIDTH_STATE = 3) (
  input  logic [3:0] acsnoop,
  input  logic hit,
  input  logic [WIDTH_STATE-1:0] state,
  output logic [CRRESP_W-1:0] crresp,
  output logic [WIDTH_STATE-1:0] new_state,
  output logic we
);
  logic valid, uniq, dirty, ro, rs, ru, ci, mi;
  assign valid = hit && state != WIDTH_STATE'(ST_I);
  assign uniq = state == WIDTH_STATE'(ST_UC) || state == WIDTH_STATE'(ST_UD);
  assign dirty = state == WIDTH_STATE'(ST_UD) || state == WIDTH_STATE'(ST_SD);
  assign ro = valid && acsnoop == SN_READ_ONCE;
  assign rs = valid && acsnoop == SN_READ_SHARED;
  assign ru = valid && acsnoop == SN_READ_UNIQUE;
  assign ci = valid && acsnoop == SN_CLEAN_INVALID;
  assign mi = valid && acsnoop == SN_MAKE_INVALID;
  assign crresp[CR_DT] = ro || rs || ru || (ci && dirty);
  assign crresp[CR_ERR] = 1'b0;
  assign crresp[CR_PD] = (rs || ru || ci) && dirty;
  assign crresp[CR_IS] = ro || rs;
  assign crresp[CR_WU] = (ro || rs || ru || ci || mi) && uniq;
  assign new_state = rs ? WIDTH_STATE'(ST_SC) : (ru || ci || mi) ? WIDTH_STATE'(ST_I) : state;
  assign we = new_state != state;
endmodule

// File: rtl/snoop_controller.sv
// snoop_controller: accepts one AC snoop at a time, looks up the cache, answers on CR and streams the line on CD.
module snoop_controller import cache_pkg::*; #(
  parameter int WIDTH_STATE = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BEATS = 4
) (
  input  logic clk,
  input  logic reset,
  snoop_controller_if.slave bus,
  input  logic cache_busy,
  output logic snoop_busy,
  output logic snoop_lookup,
  output logic [ADDR_WIDTH-1:0] snoop_addr,
  input  logic snoop_hit,
  input  logic [WIDTH_STATE-1:0] snoop_line_state,
  input  logic [DATA_WIDTH*LINE_BEATS-1:0] snoop_line_data,
  output logic snoop_state_we,
  output logic [WIDTH_STATE-1:0] snoop_new_state
);
  localparam int BW = LINE_BEATS > 1 ? $clog2(LINE_BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(LINE_BEATS - 1);
  snoop_fsm_e fsm;
  logic [3:0] snoop_r;
  logic [DATA_WIDTH*LINE_BEATS-1:0] line_r;
  logic [CRRESP_W-1:0] crresp_r, dec_resp;
  logic [WIDTH_STATE-1:0] ns_r, dec_state;
  logic we_r, dec_we, crvalid_r, cdvalid_r;
  logic [BW-1:0] beat;
  snoop_resp_decode #(.WIDTH_STATE(WIDTH_STATE)) u_decode (
    .acsnoop(snoop_r), .hit(snoop_hit), .state(snoop_line_state),
    .crresp(dec_resp), .new_state(dec_state), .we(dec_we)
  );
  assign snoop_busy = fsm != IDLE;
  assign bus.acready = fsm == IDLE && !cache_busy;
  assign bus.crvalid = crvalid_r;
  assign bus.crresp = crresp_r;
  assign bus.cdvalid = cdvalid_r;
  assign bus.cddata = line_r[beat*DATA_WIDTH +: DATA_WIDTH];
  assign bus.cdlast = cdvalid_r && beat == LAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm <= IDLE;
      snoop_r <= '0;
      snoop_addr <= '0;
      line_r <= '0;
      crresp_r <= '0;
      ns_r <= '0;
      we_r <= 1'b0;
      beat <= '0;
      snoop_lookup <= 1'b0;
      crvalid_r <= 1'b0;
      cdvalid_r <= 1'b0;
      snoop_state_we <= 1'b0;
      snoop_new_state <= '0;
    end else begin
      case (fsm)
        IDLE: if (bus.acvalid && !cache_busy) begin
          snoop_addr <= bus.acaddr;
          snoop_r <= bus.acsnoop;
          snoop_lookup <= 1'b1;
          fsm <= LOOKUP;
        end
        LOOKUP: begin
          snoop_lookup <= 1'b0;
          line_r <= snoop_line_data;
          crresp_r <= dec_resp;
          ns_r <= dec_state;
          we_r <= dec_we;
          crvalid_r <= 1'b1;
          fsm <= RESP;
        end
        RESP: if (bus.crready) begin
          crvalid_r <= 1'b0;
          beat <= '0;
          cdvalid_r <= crresp_r[CR_DT];
          snoop_state_we <= !crresp_r[CR_DT] && we_r;
          snoop_new_state <= ns_r;
          fsm <= crresp_r[CR_DT] ? DATA : UPDATE;
        end
        DATA: if (bus.cdready) begin
          beat <= beat == LAST ? beat : beat + 1'b1;
          cdvalid_r <= beat != LAST;
          snoop_state_we <= beat == LAST && we_r;
          fsm <= beat == LAST ? UPDATE : DATA;
        end
        UPDATE: begin
          snoop_state_we <= 1'b0;
          fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snoop_controller.sv
// tb_snoop_controller: table-driven and randomized checks of snoop_controller against a rule-level model.
module tb_snoop_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cache_busy = 1'b0;
  logic snoop_busy, snoop_lookup, snoop_hit, snoop_state_we;
  logic [31:0] snoop_addr;
  logic [2:0] snoop_line_state, snoop_new_state;
  logic [127:0] snoop_line_data;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  snoop_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  snoop_controller dut (
    .clk(clk), .reset(reset), .bus(bus), .cache_busy(cache_busy), .snoop_busy(snoop_busy),
    .snoop_lookup(snoop_lookup), .snoop_addr(snoop_addr), .snoop_hit(snoop_hit),
    .snoop_line_state(snoop_line_state), .snoop_line_data(snoop_line_data),
    .snoop_state_we(snoop_state_we), .snoop_new_state(snoop_new_state)
  );
  typedef struct {
    logic [3:0] sn;
    logic hit;
    logic [2:0] st;
    logic [127:0] line;
    int stall;
    int busy;
    logic [4:0] er;
    logic ewe;
    logic [2:0] ens;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response rules written directly from the snoop-type table: {WU, IS, PD, Err, DT}.
  function automatic void model(input logic [3:0] sn, input logic hit, input logic [2:0] st,
                                output logic [4:0] r, output logic we, output logic [2:0] ns);
    logic uq, dt, ok;
    uq = st == 3'd0 || st == 3'd1;
    dt = st == 3'd1 || st == 3'd3;
    ok = hit && st != 3'd4;
    r = 5'b0;
    ns = st;
    if (ok) begin
      if (sn == 4'd0) r = {uq, 1'b1, 1'b0, 1'b0, 1'b1};
      if (sn == 4'd1) begin r = {uq, 1'b1, dt, 1'b0, 1'b1}; ns = 3'd2; end
      if (sn == 4'd7) begin r = {uq, 1'b0, dt, 1'b0, 1'b1}; ns = 3'd4; end
      if (sn == 4'd9) begin r = {uq, 1'b0, dt, 1'b0, dt}; ns = 3'd4; end
      if (sn == 4'd13) begin r = {uq, 4'b0}; ns = 3'd4; end
    end
    we = ns != st;
  endfunction

  task automatic run_snoop(input vec_t v);
    logic [31:0] a;
    a = $urandom;
    @(negedge clk);
    bus.acvalid = 1'b1;
    bus.acaddr = a;
    bus.acsnoop = v.sn;
    for (int i = 0; i < v.busy; i++) begin
      cache_busy = 1'b1;
      #1 chk("acready_blocked", bus.acready, 1'b0);
      @(negedge clk);
      chk("no_lookup_while_busy", {snoop_lookup, snoop_busy}, 2'b00);
    end
    cache_busy = 1'b0;
    #1 chk("acready_idle", bus.acready, 1'b1);
    @(negedge clk);
    bus.acvalid = 1'b0;
    chk("lookup_strobe", snoop_lookup, 1'b1);
    chk("lookup_addr", snoop_addr, a);
    chk("crvalid_in_lookup", bus.crvalid, 1'b0);
    snoop_hit = v.hit;
    snoop_line_state = v.st;
    snoop_line_data = v.line;
    cache_busy = v.busy > 0;
    #1 chk("acready_busy", bus.acready, 1'b0);
    @(negedge clk);
    snoop_hit = $urandom;
    snoop_line_state = $urandom;
    snoop_line_data = {$urandom, $urandom, $urandom, $urandom};
    chk("crvalid", bus.crvalid, 1'b1);
    chk("crresp", bus.crresp, v.er);
    chk("lookup_one_cycle", snoop_lookup, 1'b0);
    repeat (v.stall) begin
      @(negedge clk);
      chk("crvalid_stall", bus.crvalid, 1'b1);
      chk("crresp_stall", bus.crresp, v.er);
    end
    bus.crready = 1'b1;
    @(negedge clk);
    bus.crready = 1'b0;
    chk("crvalid_drop", bus.crvalid, 1'b0);
    if (v.er[0]) begin
      for (int k = 0; k < 4; k++) begin
        chk("cdvalid", bus.cdvalid, 1'b1);
        chk("cddata", bus.cddata, v.line[k*32 +: 32]);
        chk("cdlast", bus.cdlast, k == 3);
        chk("we_in_data", snoop_state_we, 1'b0);
        if (k == 1)
          repeat (v.stall) begin
            @(negedge clk);
            chk("cddata_stall", {bus.cdvalid, bus.cddata}, {1'b1, v.line[63:32]});
          end
        bus.cdready = 1'b1;
        @(negedge clk);
        bus.cdready = 1'b0;
      end
    end
    chk("update_cdvalid", bus.cdvalid, 1'b0);
    chk("update_we", snoop_state_we, v.ewe);
    if (v.ewe) chk("update_state", snoop_new_state, v.ens);
    chk("update_busy", snoop_busy, 1'b1);
    cache_busy = 1'b0;
    @(negedge clk);
    chk("back_idle", {snoop_busy, snoop_state_we, bus.crvalid, bus.cdvalid}, 4'b0);
    #1 chk("acready_after", bus.acready, 1'b1);
  endtask

  initial begin
    vec_t v;
    bus.acvalid = 1'b0;
    bus.acaddr = '0;
    bus.acsnoop = '0;
    bus.crready = 1'b0;
    bus.cdready = 1'b0;
    snoop_hit = 1'b0;
    snoop_line_state = 3'd4;
    snoop_line_data = '0;
    vecs[0] = '{4'd1, 1'b1, 3'd1, 128'h00004444_00003333_00002222_00001111, 0, 0, 5'b11101, 1'b1, 3'd2};
    vecs[1] = '{4'd7, 1'b1, 3'd2, 128'h0, 0, 0, 5'b00001, 1'b1, 3'd4};
    vecs[2] = '{4'd13, 1'b1, 3'd0, 128'h0, 0, 0, 5'b10000, 1'b1, 3'd4};
    vecs[3] = '{4'd1, 1'b0, 3'd1, 128'h0, 0, 0, 5'b00000, 1'b0, 3'd0};
    vecs[4] = '{4'd7, 1'b1, 3'd2, 128'h0, 3, 2, 5'b00001, 1'b1, 3'd4};
    vecs[5] = '{4'd0, 1'b1, 3'd1, 128'h0, 1, 0, 5'b11001, 1'b0, 3'd0};
    vecs[6] = '{4'd9, 1'b1, 3'd3, 128'h0, 0, 0, 5'b00101, 1'b1, 3'd4};
    vecs[7] = '{4'd9, 1'b1, 3'd2, 128'h0, 0, 0, 5'b00000, 1'b1, 3'd4};
    vecs[8] = '{4'd3, 1'b1, 3'd0, 128'h0, 0, 0, 5'b00000, 1'b0, 3'd0};
    vecs[9] = '{4'd7, 1'b1, 3'd4, 128'h0, 0, 0, 5'b00000, 1'b0, 3'd0};
    repeat (2) @(negedge clk);
    chk("reset_outputs", {snoop_busy, snoop_lookup, snoop_state_we, bus.crvalid, bus.cdvalid, bus.cdlast, bus.crresp}, 11'b0);
    chk("reset_acready", bus.acready, 1'b1);
    cache_busy = 1'b1;
    #1 chk("reset_acready_busy", bus.acready, 1'b0);
    cache_busy = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      if (i != 0) v.line = {$urandom, $urandom, $urandom, $urandom};
      run_snoop(v);
    end
    for (int i = 0; i < 40; i++) begin
      logic [3:0] codes[6];
      codes = '{4'd0, 4'd1, 4'd7, 4'd9, 4'd13, 4'($urandom)};
      v.sn = codes[$urandom_range(0, 5)];
      v.hit = $urandom;
      v.st = 3'($urandom_range(0, 4));
      v.line = {$urandom, $urandom, $urandom, $urandom};
      v.stall = $urandom_range(0, 2);
      v.busy = $urandom_range(0, 1);
      model(v.sn, v.hit, v.st, v.er, v.ewe, v.ens);
      run_snoop(v);
    end
    // Reset during the third data beat must abandon the transfer without a state write.
    @(negedge clk);
    bus.acvalid = 1'b1;
    bus.acsnoop = 4'd1;
    @(negedge clk);
    bus.acvalid = 1'b0;
    snoop_hit = 1'b1;
    snoop_line_state = 3'd1;
    snoop_line_data = 128'h00004444_00003333_00002222_00001111;
    @(negedge clk);
    bus.crready = 1'b1;
    @(negedge clk);
    bus.crready = 1'b0;
    bus.cdready = 1'b1;
    repeat (2) @(negedge clk);
    bus.cdready = 1'b0;
    chk("rst_beat2_data", {bus.cdvalid, bus.cddata}, {1'b1, 32'h3333});
    reset = 1'b1;
    cache_busy = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_cdvalid", {bus.cdvalid, bus.crvalid, snoop_state_we, snoop_busy}, 4'b0);
    chk("rst_acready_busy", bus.acready, 1'b0);
    cache_busy = 1'b0;
    #1 chk("rst_acready", bus.acready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("rst_quiet", {bus.cdvalid, bus.crvalid, snoop_state_we, snoop_busy}, 4'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
